// File: rtl/seq_divider.sv
// Multi-cycle restoring divider: one quotient bit per clock, MSB first, with
// valid/ready handshakes, optional two's-complement operands and divide-by-zero flag.
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     dividend,
  input  logic [WIDTH-1:0]     divisor,
  input  logic                 signed_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   result,
  output logic                 div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t               state_reg, state_next;
  logic [WIDTH-1:0]     dq_reg;      // dividend magnitude shifting out, quotient shifting in
  logic [WIDTH-1:0]     dsr_reg;
  logic [WIDTH-1:0]     rem_reg;
  logic [CW-1:0]        cnt_reg;
  logic                 neg_q_reg;
  logic                 neg_r_reg;
  logic [2*WIDTH-1:0]   result_reg;
  logic                 dbz_reg;

  logic                 dvd_neg, dsr_neg, divisor_zero, last_step, step_ge;
  logic [WIDTH-1:0]     dvd_mag, dsr_mag, rem_new, q_new, q_fix, r_fix;
  logic [WIDTH:0]       rem_shift, rem_diff;

  assign dvd_neg      = signed_mode & dividend[WIDTH-1];
  assign dsr_neg      = signed_mode & divisor[WIDTH-1];
  assign dvd_mag      = dvd_neg ? -dividend : dividend;
  assign dsr_mag      = dsr_neg ? -divisor : divisor;
  assign divisor_zero = (divisor == '0);
  assign last_step    = (cnt_reg == '0);

  // The partial remainder before the shift is always below the divisor, so the
  // WIDTH+1 bit difference never wraps and its top bit is a clean borrow.
  assign rem_shift = {rem_reg, dq_reg[WIDTH-1]};
  assign rem_diff  = rem_shift - {1'b0, dsr_reg};
  assign step_ge   = ~rem_diff[WIDTH];
  assign rem_new   = step_ge ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
  assign q_new     = {dq_reg[WIDTH-2:0], step_ge};
  assign q_fix     = neg_q_reg ? -q_new : q_new;
  assign r_fix     = neg_r_reg ? -rem_new : rem_new;

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid) state_next = divisor_zero ? DONE : CALC;
      CALC:    if (last_step) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dq_reg     <= '0;
      dsr_reg    <= '0;
      rem_reg    <= '0;
      cnt_reg    <= '0;
      neg_q_reg  <= 1'b0;
      neg_r_reg  <= 1'b0;
      result_reg <= '0;
      dbz_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            dq_reg    <= dvd_mag;
            dsr_reg   <= dsr_mag;
            rem_reg   <= '0;
            cnt_reg   <= CW'(WIDTH - 1);
            neg_q_reg <= dvd_neg ^ dsr_neg;
            neg_r_reg <= dvd_neg;
            dbz_reg   <= divisor_zero;
            if (divisor_zero) result_reg <= {{WIDTH{1'b1}}, dividend};
          end
        end
        CALC: begin
          rem_reg <= rem_new;
          dq_reg  <= q_new;
          cnt_reg <= cnt_reg - CW'(1);
          if (last_step) result_reg <= {q_fix, r_fix};
        end
        default: ;
      endcase
    end
  end

  assign in_ready    = (state_reg == IDLE);
  assign out_valid   = (state_reg == DONE);
  assign result      = result_reg;
  assign div_by_zero = dbz_reg;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (WIDTH=8): directed corner cases plus
// random operations compared against an integer-arithmetic reference model.
module tb_seq_divider;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   dividend = '0;
  logic [W-1:0]   divisor = '0;
  logic           signed_mode = 1'b0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [2*W-1:0] result;
  logic           div_by_zero;

  int checks = 0;
  int errors = 0;

  seq_divider #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor), .signed_mode(signed_mode),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reference: plain integer division (truncating, remainder follows dividend).
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm,
                       output logic [2*W-1:0] r, output logic dbz);
    int sa, sb, q, m;
    if (b == 0) begin
      r   = {8'hFF, a};
      dbz = 1'b1;
    end else begin
      if (sm) begin
        sa = $signed(a);
        sb = $signed(b);
      end else begin
        sa = int'({24'b0, a});
        sb = int'({24'b0, b});
      end
      q   = sa / sb;
      m   = sa % sb;
      r   = {q[7:0], m[7:0]};
      dbz = 1'b0;
    end
  endtask

  // Called at a negedge while the DUT is idle; returns at a negedge, idle again.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm,
                        input int hold, input logic [2*W-1:0] fixed_exp, input bit use_fixed);
    logic [2*W-1:0] expr;
    logic           expd;
    int             lat;
    model(a, b, sm, expr, expd);
    if (use_fixed) chk("model_vs_table", {16'b0, expr}, {16'b0, fixed_exp});
    chk("in_ready_idle", {31'b0, in_ready}, 32'd1);
    in_valid = 1'b1; dividend = a; divisor = b; signed_mode = sm;
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      // junk on the input side must not disturb the running operation
      in_valid = 1'b1; dividend = W'($urandom); divisor = W'($urandom); signed_mode = 1'($urandom);
      if (!out_valid && lat < 40) @(posedge clk);
    end while (!out_valid && lat < 40);
    chk("latency", lat, (b == 0) ? 32'd1 : 32'(W + 1));
    chk("result", {16'b0, result}, {16'b0, expr});
    chk("div_by_zero", {31'b0, div_by_zero}, {31'b0, expd});
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      @(negedge clk);
      chk("hold_valid", {31'b0, out_valid}, 32'd1);
      chk("hold_result", {16'b0, result}, {16'b0, expr});
      chk("hold_in_ready", {31'b0, in_ready}, 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("release_valid", {31'b0, out_valid}, 32'd0);
    chk("release_in_ready", {31'b0, in_ready}, 32'd1);
    $display("op a=%h b=%h signed=%0d result=%h dbz=%0d lat=%0d", a, b, sm, result, div_by_zero, lat);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_result", {16'b0, result}, 32'd0);
    chk("rst_dbz", {31'b0, div_by_zero}, 32'd0);
    rst = 1'b0;

    run_op(8'd100, 8'd7,   1'b0, 0, 16'h0E02, 1'b1);
    run_op(8'h9C,  8'h07,  1'b1, 0, 16'hF2FE, 1'b1);
    run_op(8'd100, 8'hF9,  1'b1, 0, 16'hF202, 1'b1);
    run_op(8'h80,  8'hFF,  1'b1, 0, 16'h8000, 1'b1);
    run_op(8'hFF,  8'h01,  1'b0, 0, 16'hFF00, 1'b1);
    run_op(8'd55,  8'd0,   1'b0, 0, 16'hFF37, 1'b1);
    run_op(8'd37,  8'd5,   1'b0, 5, 16'h0702, 1'b1);
    run_op(8'h80,  8'h01,  1'b1, 0, 16'h8000, 1'b1);

    // reset while the bit-4 step is pending
    in_valid = 1'b1; dividend = 8'd123; divisor = 8'd9; signed_mode = 1'b0;
    @(posedge clk);
    repeat (3) @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("midcalc_rst_valid", {31'b0, out_valid}, 32'd0);
    chk("midcalc_rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("midcalc_rst_result", {16'b0, result}, 32'd0);
    run_op(8'd200, 8'd13, 1'b0, 0, 16'h0F05, 1'b1);

    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      run_op(ra, rb, 1'($urandom), $urandom_range(0, 2), '0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
